// File: rtl/mz_pulse_sequencer.sv
// Mach-Zehnder RF gate sequencer: trigger -> DEAD, P1 (pi/2), W1, P2 (pi), W2, P3 (pi/2).
// A single down-counter times every segment; all outputs are registered from next-state.
module mz_pulse_sequencer #(
  parameter int CNT_W  = 17,
  parameter int START  = 66666,
  parameter int PI_2   = 333,
  parameter int PI     = 666,
  parameter int WAIT   = 66666,
  parameter int SHOT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              cont,
  input  logic              abort,
  output logic              rf,
  output logic              busy,
  output logic              done,
  output logic [2:0]        seg,
  output logic [SHOT_W-1:0] shots
);

  localparam longint LIM = longint'(1) << CNT_W;

  if (START < 1 || PI_2 < 1 || PI < 1 || WAIT < 1 ||
      START >= LIM || PI_2 >= LIM || PI >= LIM || WAIT >= LIM) begin : g_len_chk
    $error("mz_pulse_sequencer: segment length must be in [1, 2**CNT_W)");
  end

  localparam logic [CNT_W-1:0] START_M1 = CNT_W'(START - 1);
  localparam logic [CNT_W-1:0] PI2_M1   = CNT_W'(PI_2 - 1);
  localparam logic [CNT_W-1:0] PI_M1    = CNT_W'(PI - 1);
  localparam logic [CNT_W-1:0] WAIT_M1  = CNT_W'(WAIT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, DEAD = 3'd1, P1 = 3'd2, W1 = 3'd3, P2 = 3'd4, W2 = 3'd5, P3 = 3'd6
  } state_t;

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sync1, sync2, hist;
  logic             start, seg_end, fin;

  function automatic logic [CNT_W-1:0] len_m1(state_t s);
    case (s)
      DEAD:    return START_M1;
      P1, P3:  return PI2_M1;
      W1, W2:  return WAIT_M1;
      P2:      return PI_M1;
      default: return '0;
    endcase
  endfunction

  // Two-flop synchroniser plus history flop; only a 0->1 edge starts a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= trig;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign start   = sync2 & ~hist;
  assign seg_end = (cnt == '0);

  always_comb begin
    nstate  = state;
    fin     = 1'b0;
    case (state)
      IDLE: if (start)   nstate = DEAD;
      DEAD: if (seg_end) nstate = P1;
      P1:   if (seg_end) nstate = W1;
      W1:   if (seg_end) nstate = P2;
      P2:   if (seg_end) nstate = W2;
      W2:   if (seg_end) nstate = P3;
      P3:   if (seg_end) begin
        fin    = 1'b1;
        nstate = cont ? DEAD : IDLE;
      end
      default: nstate = IDLE;
    endcase
    if (abort) begin
      nstate = IDLE;
      fin    = 1'b0;
    end
    // Every transition enters a different state, so a state change marks segment entry.
    cnt_nxt = (state == IDLE) ? '0 : cnt - CNT_W'(1);
    if (nstate != state) cnt_nxt = len_m1(nstate);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rf    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      seg   <= 3'd0;
      shots <= '0;
    end else begin
      state <= nstate;
      cnt   <= cnt_nxt;
      rf    <= (nstate == P1) || (nstate == P2) || (nstate == P3);
      busy  <= (nstate != IDLE);
      seg   <= nstate;
      done  <= fin;
      if (fin) shots <= shots + SHOT_W'(1);
    end
  end

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
// Bench for mz_pulse_sequencer: elapsed-time model compared every cycle, plus directed literal checks.
module tb_mz_pulse_sequencer;

  localparam int ST  = 4;
  localparam int P2L = 3;
  localparam int PIL = 6;
  localparam int WL  = 5;
  localparam int T   = ST + P2L + WL + PIL + WL + P2L;

  logic        clk, rst_n, trig, cont, abort;
  logic        rf, busy, done;
  logic [2:0]  seg;
  logic [15:0] shots;

  logic        trig2, cont2, abort2;
  logic        rf2, busy2, done2;
  logic [2:0]  seg2;
  logic [1:0]  shots2;

  mz_pulse_sequencer #(.CNT_W(17), .START(ST), .PI_2(P2L), .PI(PIL), .WAIT(WL), .SHOT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .cont(cont), .abort(abort),
    .rf(rf), .busy(busy), .done(done), .seg(seg), .shots(shots));

  mz_pulse_sequencer #(.CNT_W(17), .START(4), .PI_2(333), .PI(666), .WAIT(5), .SHOT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .trig(trig2), .cont(cont2), .abort(abort2),
    .rf(rf2), .busy(busy2), .done(done2), .seg(seg2), .shots(shots2));

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is just elapsed cycles since DEAD entry; segment follows from cumulative lengths.
  bit          h1, h2, h3, st_edge;
  bit          m_busy, m_done, m_rf;
  int          m_el, m_seg;
  logic [15:0] m_shots;

  function automatic int seg_of(input int el);
    if (el < ST)                       return 1;
    if (el < ST + P2L)                 return 2;
    if (el < ST + P2L + WL)            return 3;
    if (el < ST + P2L + WL + PIL)      return 4;
    if (el < ST + P2L + WL + PIL + WL) return 5;
    return 6;
  endfunction

  initial begin
    h1 = 0; h2 = 0; h3 = 0; m_busy = 0; m_done = 0; m_el = 0; m_shots = '0; m_seg = 0; m_rf = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        h1 = 0; h2 = 0; h3 = 0; m_busy = 0; m_done = 0; m_el = 0; m_shots = '0;
      end else begin
        st_edge = h2 & ~h3;
        m_done  = 0;
        if (abort) m_busy = 0;
        else if (m_busy) begin
          m_el++;
          if (m_el == T) begin
            m_done  = 1;
            m_shots = m_shots + 16'd1;
            m_el    = 0;
            m_busy  = cont;
          end
        end else if (st_edge) begin
          m_busy = 1;
          m_el   = 0;
        end
        h3 = h2; h2 = h1; h1 = trig;
      end
      m_seg = m_busy ? seg_of(m_el) : 0;
      m_rf  = m_busy && (m_seg == 2 || m_seg == 4 || m_seg == 6);
    end
  end

  bit sel2 = 0;
  bit rf_log[$];
  int done_cnt = 0;
  int shots2_q[$];
  int runs[$];

  always @(posedge clk) begin
    #2;
    rf_log.push_back(sel2 ? rf2 : rf);
    if (done)  done_cnt++;
    if (done2) shots2_q.push_back(int'(shots2));
    chk("cyc_rf",    int'(rf),    int'(m_rf));
    chk("cyc_busy",  int'(busy),  int'(m_busy));
    chk("cyc_done",  int'(done),  int'(m_done));
    chk("cyc_seg",   int'(seg),   m_seg);
    chk("cyc_shots", int'(shots), int'(m_shots));
  end

  // Run lengths of rf starting at its first high cycle; a trailing low run is dropped.
  task automatic build_runs();
    bit v, started;
    int cur;
    runs.delete();
    started = 0; v = 0; cur = 0;
    foreach (rf_log[i]) begin
      if (!started) begin
        if (rf_log[i]) begin started = 1; v = 1; cur = 1; end
      end else if (rf_log[i] == v) cur++;
      else begin
        runs.push_back(cur);
        v = rf_log[i];
        cur = 1;
      end
    end
    if (started && v) runs.push_back(cur);
  endtask

  task automatic check_seq(input string nm, input int base, input int a, input int b, input int c);
    if (runs.size() < base + 5) chk({nm, "_nruns"}, runs.size(), base + 5);
    else begin
      chk({nm, "_p1"}, runs[base],     a);
      chk({nm, "_w1"}, runs[base + 1], b);
      chk({nm, "_p2"}, runs[base + 2], c);
      chk({nm, "_w2"}, runs[base + 3], b);
      chk({nm, "_p3"}, runs[base + 4], a);
    end
  endtask

  task automatic clear_logs();
    rf_log.delete();
    shots2_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_trig(input int n);
    trig = 1'b1;
    repeat (n) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_seg(input int v, input int budget, input string nm);
    int n = 0;
    while (int'(seg) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(seg) != v) chk(nm, int'(seg), v);
  endtask

  task automatic wait_busy(input bit which, input bit v, input int budget, input string nm);
    int n = 0;
    while ((which ? busy2 : busy) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if ((which ? busy2 : busy) != v) chk(nm, int'(which ? busy2 : busy), int'(v));
  endtask

  int k;

  initial begin
    rst_n = 1'b0; trig = 0; cont = 0; abort = 0; trig2 = 0; cont2 = 0; abort2 = 0;
    @(negedge clk);
    do_reset();

    // 1: reset state, single 2-cycle trigger
    chk("rst_rf", int'(rf), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_seg", int'(seg), 0);
    chk("rst_shots", int'(shots), 0);
    clear_logs();
    trig = 1'b1;
    k = 0;
    while (k < 50) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 2) trig = 1'b0;
      if (rf) break;
    end
    trig = 1'b0;
    chk("t1_first_rise_edge", k - 1, 6);
    wait_busy(0, 0, 100, "t1_idle_timeout");
    build_runs();
    check_seq("t1", 0, 3, 5, 6);
    chk("t1_nruns", runs.size(), 5);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_shots", int'(shots), 1);

    // 2a: held trigger level runs exactly once
    do_reset();
    clear_logs();
    trig = 1'b1;
    repeat (100) @(negedge clk);
    trig = 1'b0;
    wait_busy(0, 0, 50, "t2a_idle_timeout");
    chk("t2a_done_cnt", done_cnt, 1);
    chk("t2a_shots", int'(shots), 1);

    // 2b: trigger during W1 is dropped
    do_reset();
    clear_logs();
    pulse_trig(2);
    wait_seg(3, 60, "t2b_w1_timeout");
    pulse_trig(2);
    wait_busy(0, 0, 100, "t2b_idle_timeout");
    repeat (20) @(negedge clk);
    chk("t2b_busy_after", int'(busy), 0);
    chk("t2b_shots", int'(shots), 1);

    // 3: continuous mode, cont cleared in run 3
    do_reset();
    clear_logs();
    cont = 1'b1;
    pulse_trig(2);
    k = 0;
    while (done_cnt < 2 && k < 200) begin @(negedge clk); k++; end
    chk("t3_two_done_seen", int'(done_cnt >= 2), 1);
    wait_seg(3, 60, "t3_w1_timeout");
    cont = 1'b0;
    wait_busy(0, 0, 200, "t3_idle_timeout");
    build_runs();
    chk("t3_nruns", runs.size(), 17);
    check_seq("t3_s1", 0, 3, 5, 6);
    if (runs.size() >= 12) begin
      chk("t3_gap1", runs[5], 4);
      chk("t3_gap2", runs[11], 4);
    end
    chk("t3_done_cnt", done_cnt, 3);
    chk("t3_shots", int'(shots), 3);

    // 4: abort in cycle 2 of P2, then abort held in IDLE, then a clean run
    do_reset();
    clear_logs();
    pulse_trig(2);
    wait_seg(4, 60, "t4_p2_timeout");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_rf", int'(rf), 0);
    chk("t4_abort_busy", int'(busy), 0);
    chk("t4_abort_seg", int'(seg), 0);
    repeat (5) @(negedge clk);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_shots_kept", int'(shots), 0);
    abort = 1'b1;
    pulse_trig(2);
    repeat (6) @(negedge clk);
    chk("t4_abort_blocks_start", int'(busy), 0);
    abort = 1'b0;
    clear_logs();
    pulse_trig(2);
    wait_busy(0, 1, 10, "t4_start_timeout");
    wait_busy(0, 0, 100, "t4_idle_timeout");
    build_runs();
    check_seq("t4", 0, 3, 5, 6);
    chk("t4_shots", int'(shots), 1);

    // 5: asynchronous reset mid-P1
    clear_logs();
    pulse_trig(2);
    wait_seg(2, 60, "t5_p1_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rf", int'(rf), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_seg", int'(seg), 0);
    chk("t5_async_shots", int'(shots), 0);
    chk("t5_async_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_no_restart", int'(busy), 0);
    chk("t5_no_done", done_cnt, 0);
    clear_logs();
    pulse_trig(2);
    wait_busy(0, 1, 10, "t5_start_timeout");
    wait_busy(0, 0, 100, "t5_idle_timeout");
    build_runs();
    check_seq("t5", 0, 3, 5, 6);
    chk("t5_shots", int'(shots), 1);

    // 6: long pulses, 2-bit shot counter wrapping in continuous mode
    do_reset();
    clear_logs();
    sel2 = 1'b1;
    cont2 = 1'b1;
    trig2 = 1'b1;
    repeat (2) @(negedge clk);
    trig2 = 1'b0;
    k = 0;
    while (shots2_q.size() < 4 && k < 7000) begin @(negedge clk); k++; end
    cont2 = 1'b0;
    wait_busy(1, 0, 2000, "t6_idle_timeout");
    build_runs();
    check_seq("t6", 0, 333, 5, 666);
    if (runs.size() >= 6) chk("t6_gap", runs[5], 4);
    if (shots2_q.size() < 4) chk("t6_nshots", shots2_q.size(), 4);
    else begin
      chk("t6_shots_1", shots2_q[0], 1);
      chk("t6_shots_2", shots2_q[1], 2);
      chk("t6_shots_3", shots2_q[2], 3);
      chk("t6_shots_4", shots2_q[3], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
